// File: rtl/tdm_pkg.sv
// Shared TDM lane-mux definitions: FSM encoding, default geometry, lane-index width.
// Used by both the receive demux and the transmit-side serializer.
package tdm_pkg;

   typedef enum logic {
      HUNT    = 1'b0,
      COLLECT = 1'b1
   } tdm_state_t;

   localparam int unsigned DEF_CH_W    = 4;
   localparam int unsigned DEF_N_CH    = 4;
   localparam int unsigned DEF_TIMEOUT = 255;
   localparam int unsigned IDLE_W      = 16;

   function automatic int unsigned lane_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tdm_timeout_ctr.sv
// Saturating idle-cycle counter; expired fires on the LIMIT-th consecutive inc cycle.
module tdm_timeout_ctr
   import tdm_pkg::*;
#(
   parameter int unsigned LIMIT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam logic [IDLE_W-1:0] LIM = IDLE_W'(LIMIT);

   logic [IDLE_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != LIM)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // cnt holds completed idle cycles, so the current one is the LIMIT-th when cnt reaches LIMIT-1
   assign expired = inc && !clr && (cnt >= (LIM - 1'b1));

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM lane demultiplexer: rebuilds N_CH*CH_W-bit frames from tagged lane beats.
// Optional `define TDM_PARITY_EN adds par/par_err even-parity checking per beat.
module tdm_demux_rx
   import tdm_pkg::*;
#(
   parameter int unsigned CH_W    = DEF_CH_W,
   parameter int unsigned N_CH    = DEF_N_CH,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     valid,
   input  logic                     sof,
   input  logic [lane_w(N_CH)-1:0]  sel,
   input  logic [CH_W-1:0]          din,
`ifdef TDM_PARITY_EN
   input  logic                     par,
   output logic                     par_err,
`endif
   output logic [N_CH*CH_W-1:0]     dout,
   output logic                     frame_done,
   output logic                     locked,
   output logic                     seq_err
);

   localparam int unsigned SEL_W = lane_w(N_CH);
   localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

   tdm_state_t                     state;
   logic [SEL_W-1:0]               exp_lane;
   logic [N_CH-2:0][CH_W-1:0]      shadow;

   logic counting;
   logic tmo_expired;
   logic par_ok;
   logic beat_ok;
   logic start;

   assign counting = en && (state == COLLECT) && (exp_lane != '0) && !valid;
   assign start    = sof && (sel == '0);
   assign beat_ok  = (sel == exp_lane) && (sof == (exp_lane == '0));

`ifdef TDM_PARITY_EN
   assign par_ok = ~^{din, par};
`else
   assign par_ok = 1'b1;
`endif

   tdm_timeout_ctr #(
      .LIMIT (TIMEOUT)
   ) u_tmo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (!counting),
      .inc     (counting),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HUNT;
         exp_lane   <= '0;
         shadow     <= '0;
         dout       <= '0;
         frame_done <= 1'b0;
         locked     <= 1'b0;
         seq_err    <= 1'b0;
`ifdef TDM_PARITY_EN
         par_err    <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         seq_err    <= 1'b0;
`ifdef TDM_PARITY_EN
         par_err    <= 1'b0;
`endif
         if (!en) begin
            state    <= HUNT;
            exp_lane <= '0;
            locked   <= 1'b0;
         end else if (valid && !par_ok) begin
`ifdef TDM_PARITY_EN
            par_err <= 1'b1;
`endif
            if (state == COLLECT) begin
               state    <= HUNT;
               exp_lane <= '0;
               locked   <= 1'b0;
            end
         end else begin
            case (state)
               HUNT: begin
                  if (valid && start) begin
                     shadow[0] <= din;
                     exp_lane  <= SEL_W'(1);
                     state     <= COLLECT;
                  end
               end
               COLLECT: begin
                  if (valid) begin
                     if (beat_ok) begin
                        if (exp_lane == LAST) begin
                           dout       <= {din, shadow};
                           frame_done <= 1'b1;
                           locked     <= 1'b1;
                           exp_lane   <= '0;
                        end else begin
                           for (int unsigned k = 0; k < N_CH - 1; k++) begin
                              if (sel == SEL_W'(k)) shadow[k] <= din;
                           end
                           exp_lane <= exp_lane + 1'b1;
                        end
                     end else begin
                        // an offending sof on lane 0 is itself a legal frame start
                        seq_err <= 1'b1;
                        locked  <= 1'b0;
                        if (start) begin
                           shadow[0] <= din;
                           exp_lane  <= SEL_W'(1);
                        end else begin
                           state    <= HUNT;
                           exp_lane <= '0;
                        end
                     end
                  end else if (tmo_expired) begin
                     seq_err  <= 1'b1;
                     locked   <= 1'b0;
                     state    <= HUNT;
                     exp_lane <= '0;
                  end
               end
               default: begin
                  state    <= HUNT;
                  exp_lane <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Self-checking bench for tdm_demux_rx: directed vector table, hand sequences, random vs model.
// Parity sequence is included when TDM_PARITY_EN is defined.
module tb_tdm_demux_rx;

   localparam int unsigned CH_W    = 4;
   localparam int unsigned N_CH    = 4;
   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en, valid, sof;
   logic [1:0]  sel;
   logic [3:0]  din;
   logic [15:0] dout;
   logic        frame_done, locked, seq_err;
`ifdef TDM_PARITY_EN
   logic        par, par_err;
`endif

   always #5 clk = ~clk;

   tdm_demux_rx #(
      .CH_W    (CH_W),
      .N_CH    (N_CH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .valid      (valid),
      .sof        (sof),
      .sel        (sel),
      .din        (din),
`ifdef TDM_PARITY_EN
      .par        (par),
      .par_err    (par_err),
`endif
      .dout       (dout),
      .frame_done (frame_done),
      .locked     (locked),
      .seq_err    (seq_err)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic [15:0] d, input logic dn,
                          input logic lk, input logic er);
      chk({name, ".dout"},       dout,       d);
      chk({name, ".frame_done"}, frame_done, dn);
      chk({name, ".locked"},     locked,     lk);
      chk({name, ".seq_err"},    seq_err,    er);
   endtask

   // Reference model: a frame is a list of lanes that must arrive as 0,1,..,N_CH-1.
   bit          m_track;
   logic [3:0]  m_q[$];
   int          m_idle;
   logic [15:0] m_dout;
   bit          m_locked, m_done, m_err;

   function automatic void model_reset();
      m_track = 0; m_q.delete(); m_idle = 0;
      m_dout = '0; m_locked = 0; m_done = 0; m_err = 0;
   endfunction

   task automatic model_step(input logic e, input logic v, input logic s,
                             input logic [1:0] sl, input logic [3:0] d);
      m_done = 0;
      m_err  = 0;
      if (!e) begin
         m_track = 0; m_q.delete(); m_locked = 0; m_idle = 0;
      end else if (!m_track) begin
         m_idle = 0;
         if (v && s && sl == 2'd0) begin
            m_q.delete(); m_q.push_back(d); m_track = 1;
         end
      end else if (v) begin
         m_idle = 0;
         if (int'(sl) == m_q.size() && (s == (m_q.size() == 0))) begin
            m_q.push_back(d);
            if (m_q.size() == N_CH) begin
               m_dout = '0;
               foreach (m_q[k]) m_dout = m_dout | (16'(m_q[k]) << (k * CH_W));
               m_done = 1; m_locked = 1; m_q.delete();
            end
         end else begin
            m_err = 1; m_locked = 0; m_q.delete();
            if (s && sl == 2'd0) m_q.push_back(d);
            else m_track = 0;
         end
      end else if (m_q.size() > 0) begin
         m_idle++;
         if (m_idle == TIMEOUT) begin
            m_err = 1; m_locked = 0; m_track = 0; m_q.delete(); m_idle = 0;
         end
      end
   endtask

   task automatic drive(input logic e, input logic v, input logic s, input logic [1:0] sl,
                        input logic [3:0] d, input bit bad_par = 0);
      en = e; valid = v; sof = s; sel = sl; din = d;
`ifdef TDM_PARITY_EN
      par = (^d) ^ bad_par;
`endif
      @(posedge clk);
      if (!bad_par) model_step(e, v, s, sl, d);
      @(negedge clk);
   endtask

   typedef struct {
      logic        e, v, s;
      logic [1:0]  sel;
      logic [3:0]  din;
      logic [15:0] dout;
      logic        done, lock, err;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic e, input logic v, input logic s, input logic [1:0] sl,
                               input logic [3:0] d, input logic [15:0] xd, input logic xdn,
                               input logic xlk, input logic xer);
      vec_t t;
      t.e = e; t.v = v; t.s = s; t.sel = sl; t.din = d;
      t.dout = xd; t.done = xdn; t.lock = xlk; t.err = xer;
      tbl.push_back(t);
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      en = 1'b0; valid = 1'b0; sof = 1'b0; sel = '0; din = '0;
`ifdef TDM_PARITY_EN
      par = 1'b0;
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      // 1: back-to-back frame 9,5,A,6
      add(1,1,1,0,4'h9, 16'h0000,0,0,0);
      add(1,1,0,1,4'h5, 16'h0000,0,0,0);
      add(1,1,0,2,4'hA, 16'h0000,0,0,0);
      add(1,1,0,3,4'h6, 16'h6A59,1,1,0);
      add(1,0,0,0,4'h0, 16'h6A59,0,1,0);
      // 2: frame 1,2,3,4 with 3 idle cycles between beats
      add(1,1,1,0,4'h1, 16'h6A59,0,1,0);
      for (int i = 0; i < 3; i++) add(1,0,0,0,4'h0, 16'h6A59,0,1,0);
      add(1,1,0,1,4'h2, 16'h6A59,0,1,0);
      for (int i = 0; i < 3; i++) add(1,0,0,0,4'h0, 16'h6A59,0,1,0);
      add(1,1,0,2,4'h3, 16'h6A59,0,1,0);
      for (int i = 0; i < 3; i++) add(1,0,0,0,4'h0, 16'h6A59,0,1,0);
      add(1,1,0,3,4'h4, 16'h4321,1,1,0);
      // 3: skipped lane, then recovery frame F,E,D,C
      add(1,1,1,0,4'h7, 16'h4321,0,1,0);
      add(1,1,0,1,4'h7, 16'h4321,0,1,0);
      add(1,1,0,3,4'h7, 16'h4321,0,0,1);
      add(1,1,1,0,4'hF, 16'h4321,0,0,0);
      add(1,1,0,1,4'hE, 16'h4321,0,0,0);
      add(1,1,0,2,4'hD, 16'h4321,0,0,0);
      add(1,1,0,3,4'hC, 16'hCDEF,1,1,0);

      do_reset();
      chk_out("reset", 16'h0000, 0, 0, 0);
`ifdef TDM_PARITY_EN
      chk("reset.par_err", par_err, 0);
`endif

      foreach (tbl[i]) begin
         drive(tbl[i].e, tbl[i].v, tbl[i].s, tbl[i].sel, tbl[i].din);
         chk_out($sformatf("vec%0d", i), tbl[i].dout, tbl[i].done, tbl[i].lock, tbl[i].err);
      end

      // 4: timeout two lanes in, then duplicate sof restarts the frame
      drive(1,1,1,0,4'h1);
      drive(1,1,0,1,4'h2);
      chk_out("tmo.pre", 16'hCDEF, 0, 1, 0);
      for (int i = 1; i <= int'(TIMEOUT); i++) begin
         drive(1,0,0,0,4'h0);
         if (i < int'(TIMEOUT)) chk($sformatf("tmo.idle%0d.seq_err", i), seq_err, 0);
      end
      chk_out("tmo.fire", 16'hCDEF, 0, 0, 1);
      drive(1,1,1,0,4'h3);
      chk_out("restart.sof1", 16'hCDEF, 0, 0, 0);
      drive(1,1,1,0,4'h4);
      chk_out("restart.sof2", 16'hCDEF, 0, 0, 1);
      drive(1,1,0,1,4'h5);
      drive(1,1,0,2,4'h6);
      drive(1,1,0,3,4'h7);
      chk_out("restart.done", 16'h7654, 1, 1, 0);

      // 5: drop en mid-frame, then full frame, then async reset mid-frame
      drive(1,1,1,0,4'h8);
      drive(1,1,0,1,4'h9);
      drive(0,1,0,2,4'h5);
      chk_out("en_low", 16'h7654, 0, 0, 0);
      drive(1,1,0,3,4'h5);
      chk_out("en_back.stray", 16'h7654, 0, 0, 0);
      drive(1,1,1,0,4'hA);
      drive(1,1,0,1,4'hA);
      drive(1,1,0,2,4'hA);
      drive(1,1,0,3,4'hA);
      chk_out("en_back.frame", 16'hAAAA, 1, 1, 0);
      drive(1,1,1,0,4'h1);
      drive(1,1,0,1,4'h2);
      #2 rst_n = 1'b0;
      #1 chk_out("async_rst", 16'h0000, 0, 0, 0);
      do_reset();

`ifdef TDM_PARITY_EN
      // 6: bad parity on lane 2 aborts without seq_err
      drive(1,1,1,0,4'h1);
      drive(1,1,0,1,4'h2);
      drive(1,1,0,2,4'h3, 1);
      chk_out("par.bad", 16'h0000, 0, 0, 0);
      chk("par.bad.par_err", par_err, 1);
      drive(1,0,0,0,4'h0);
      chk("par.after.par_err", par_err, 0);
      drive(1,1,1,0,4'h5);
      drive(1,1,0,1,4'h6);
      drive(1,1,0,2,4'h7);
      drive(1,1,0,3,4'h8);
      chk_out("par.good", 16'h8765, 1, 1, 0);
      chk("par.good.par_err", par_err, 0);
      do_reset();
`endif

      // random stream with occasional errors, en drops and long gaps
      begin
         int unsigned lane = 0;
         for (int c = 0; c < 3000; c++) begin
            logic e, v, s;
            logic [1:0] sl;
            logic [3:0] d;
            if ($urandom_range(0, 199) == 0) begin
               for (int g = 0; g < int'(TIMEOUT) + 3; g++) begin
                  drive(1,0,0,0,4'h0);
                  chk_out($sformatf("rnd%0d.gap%0d", c, g), m_dout, m_done, m_locked, m_err);
               end
            end
            e  = ($urandom_range(0, 99) != 0);
            v  = ($urandom_range(0, 9) < 6);
            sl = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'(lane);
            s  = (sl == 2'd0) ^ ($urandom_range(0, 29) == 0);
            d  = 4'($urandom_range(0, 15));
            if (v) lane = (int'(sl) + 1) % N_CH;
            drive(e, v, s, sl, d);
            chk_out($sformatf("rnd%0d", c), m_dout, m_done, m_locked, m_err);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
